// File: rtl/rpn_pkg.sv
// Shared types for the RPN program sequencer: opcodes, error codes,
// instruction word layout, datapath op codes and FSM states.
package rpn_pkg;

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_NEG  = 3'd1,
        OP_ADD  = 3'd2,
        OP_MUL  = 3'd3,
        OP_END  = 3'd4,
        OP_NOP5 = 3'd5,
        OP_NOP6 = 3'd6,
        OP_NOP7 = 3'd7
    } opc_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_UNDER = 2'd1,
        ERR_OVER  = 2'd2,
        ERR_NOEND = 2'd3
    } err_t;

    typedef struct packed {
        opc_t        opc;
        logic [15:0] data;
    } instr_t;

    localparam int INSTR_W = $bits(instr_t);

    localparam logic [1:0] CALC_NOP = 2'd0;
    localparam logic [1:0] CALC_NEG = 2'd1;
    localparam logic [1:0] CALC_ADD = 2'd2;
    localparam logic [1:0] CALC_MUL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_CHECK,
        S_EXEC,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/rpn_instr_fifo.sv
// Instruction FIFO: single-clock, power-of-two depth, show-ahead head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rpn_instr_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int W          = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;

    assign empty = (r_wr == r_rd);
    assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign head  = r_mem[r_rd[AW-1:0]];

    // Pointer update; flush discards everything still queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (push && !full)
                r_wr <= r_wr + 1'b1;
            if (pop && !empty)
                r_rd <= r_rd + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            r_mem[r_wr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: runs a host-loaded RPN program against the stack datapath,
// refusing any instruction whose stack-depth requirement is not met.
//
// state | meaning
// IDLE  | accept host instructions, wait for start
// CLEAR | clear the datapath stack
// FETCH | pop next instruction, or flag missing END when the FIFO runs dry
// CHECK | depth legality check against calc_cnt
// EXEC  | one-cycle datapath step
// WAIT  | let calc_cnt/calc_out settle
// DONE  | END reached, result captured
// ERR   | error latched, rest of the program flushed
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int STACK_MAX  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [18:0] in_instr,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [15:0] result,
    output logic        calc_clr,
    output logic        calc_en,
    output logic        calc_push,
    output logic [1:0]  calc_op,
    output logic [15:0] calc_d,
    input  logic [9:0]  calc_cnt,
    input  logic [15:0] calc_out
);
    localparam logic [10:0] LP_STACK_MAX = 11'(STACK_MAX);

    state_t      r_state;
    state_t      w_next;
    instr_t      r_ir;
    err_t        r_err;
    err_t        w_err_code;
    logic [15:0] r_result;
    logic        w_full, w_empty, w_push, w_pop, w_flush;
    logic        w_set_err, w_capture, w_run;
    logic [18:0] w_head;

    assign w_push = in_valid && in_ready;
    assign err    = r_err;
    assign result = r_result;

    rpn_instr_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .W         (INSTR_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (w_push),
        .pop  (w_pop),
        .flush(w_flush),
        .din  (in_instr),
        .full (w_full),
        .empty(w_empty),
        .head (w_head)
    );

    // Next-state and Moore outputs; in_ready is also held low while in reset.
    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_flush    = 1'b0;
        w_set_err  = 1'b0;
        w_err_code = ERR_NONE;
        w_capture  = 1'b0;
        w_run      = 1'b0;
        busy       = (r_state != S_IDLE);
        done       = 1'b0;
        calc_clr   = 1'b0;
        calc_en    = 1'b0;
        calc_push  = 1'b0;
        calc_op    = CALC_NOP;
        calc_d     = '0;
        in_ready   = !w_full && (r_state == S_IDLE) && !rst;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_run  = 1'b1;
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                calc_clr = 1'b1;
                w_next   = S_FETCH;
            end
            S_FETCH: begin
                if (w_empty) begin
                    w_set_err  = 1'b1;
                    w_err_code = ERR_NOEND;
                    w_next     = S_ERR;
                end else begin
                    w_pop  = 1'b1;
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                case (r_ir.opc)
                    OP_PUSH: begin
                        if ({1'b0, calc_cnt} >= LP_STACK_MAX) begin
                            w_set_err  = 1'b1;
                            w_err_code = ERR_OVER;
                            w_next     = S_ERR;
                        end else begin
                            w_next = S_EXEC;
                        end
                    end
                    OP_NEG: begin
                        if (calc_cnt == '0) begin
                            w_set_err  = 1'b1;
                            w_err_code = ERR_UNDER;
                            w_next     = S_ERR;
                        end else begin
                            w_next = S_EXEC;
                        end
                    end
                    OP_ADD, OP_MUL: begin
                        if (calc_cnt < 10'd2) begin
                            w_set_err  = 1'b1;
                            w_err_code = ERR_UNDER;
                            w_next     = S_ERR;
                        end else begin
                            w_next = S_EXEC;
                        end
                    end
                    OP_END: begin
                        w_capture = 1'b1;
                        w_next    = S_DONE;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_EXEC: begin
                calc_en = 1'b1;
                calc_d  = r_ir.data;
                w_next  = S_WAIT;
                case (r_ir.opc)
                    OP_PUSH: calc_push = 1'b1;
                    OP_NEG:  calc_op   = CALC_NEG;
                    OP_ADD:  calc_op   = CALC_ADD;
                    OP_MUL:  calc_op   = CALC_MUL;
                    default: ;
                endcase
            end
            S_WAIT: w_next = S_FETCH;
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                w_flush = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Instruction register plus the err/result registers held until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir     <= '0;
            r_err    <= ERR_NONE;
            r_result <= '0;
        end else begin
            if (w_pop)
                r_ir <= instr_t'(w_head);
            if (w_run) begin
                r_err    <= ERR_NONE;
                r_result <= '0;
            end else begin
                if (w_set_err)
                    r_err <= w_err_code;
                if (w_capture)
                    r_result <= calc_out;
            end
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: dut0 uses the default STACK_MAX, dut1 uses
// STACK_MAX=2. Each has its own behavioural stack datapath.
module tb_rpn_sequencer;
    import rpn_pkg::*;

    logic        clk;
    logic        rst;
    logic [18:0] in_instr;
    logic [1:0]  in_valid_v, start_v;
    logic [1:0]  in_ready_v, busy_v, done_v, calc_clr_v, calc_en_v, calc_push_v;
    logic [1:0]  err_v     [2];
    logic [15:0] result_v  [2];
    logic [1:0]  calc_op_v [2];
    logic [15:0] calc_d_v  [2];
    logic [9:0]  calc_cnt_v[2];
    logic [15:0] calc_out_v[2];

    int n_chk  = 0;
    int n_pass = 0;

    logic [18:0] mq[$];

    typedef struct {
        int err;
        int result;
        int en;
        int dcyc;
    } exp_t;

    typedef struct {
        string           nm;
        logic [7:0][18:0] prog;
        int              len;
        int              e_err;
        int              e_res;
        int              e_en;
        int              e_dcyc;
    } vec_t;

    rpn_sequencer #(.FIFO_DEPTH(16), .STACK_MAX(1000)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_instr(in_instr), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .err(err_v[0]), .result(result_v[0]), .calc_clr(calc_clr_v[0]), .calc_en(calc_en_v[0]),
        .calc_push(calc_push_v[0]), .calc_op(calc_op_v[0]), .calc_d(calc_d_v[0]),
        .calc_cnt(calc_cnt_v[0]), .calc_out(calc_out_v[0])
    );

    rpn_sequencer #(.FIFO_DEPTH(16), .STACK_MAX(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_instr(in_instr), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .err(err_v[1]), .result(result_v[1]), .calc_clr(calc_clr_v[1]), .calc_en(calc_en_v[1]),
        .calc_push(calc_push_v[1]), .calc_op(calc_op_v[1]), .calc_d(calc_d_v[1]),
        .calc_cnt(calc_cnt_v[1]), .calc_out(calc_out_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack datapath, one per DUT.
    logic [15:0] stk [2][1024];
    int          dcnt[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt[0] <= 0;
            dcnt[1] <= 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (calc_clr_v[d]) begin
                    dcnt[d] <= 0;
                end else if (calc_en_v[d]) begin
                    if (calc_push_v[d]) begin
                        if (dcnt[d] < 1024) begin
                            stk[d][dcnt[d]] <= calc_d_v[d];
                            dcnt[d] <= dcnt[d] + 1;
                        end
                    end else begin
                        case (calc_op_v[d])
                            2'd1: if (dcnt[d] >= 1)
                                stk[d][dcnt[d]-1] <= 16'h0 - stk[d][dcnt[d]-1];
                            2'd2: if (dcnt[d] >= 2) begin
                                stk[d][dcnt[d]-2] <= stk[d][dcnt[d]-2] + stk[d][dcnt[d]-1];
                                dcnt[d] <= dcnt[d] - 1;
                            end
                            2'd3: if (dcnt[d] >= 2) begin
                                stk[d][dcnt[d]-2] <= stk[d][dcnt[d]-2] * stk[d][dcnt[d]-1];
                                dcnt[d] <= dcnt[d] - 1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            calc_cnt_v[d] = 10'(dcnt[d]);
            calc_out_v[d] = (dcnt[d] > 0) ? stk[d][dcnt[d]-1] : 16'h0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    function automatic logic [18:0] mk(input opc_t o, input int dv);
        logic [18:0] w;
        w = {o, 16'(dv)};
        return w;
    endfunction

    function automatic vec_t mkv(input string nm, input int ee, input int er, input int een, input int edc);
        vec_t v;
        v.nm = nm; v.prog = '0; v.len = 0;
        v.e_err = ee; v.e_res = er; v.e_en = een; v.e_dcyc = edc;
        return v;
    endfunction

    function automatic vec_t ap(input vec_t vi, input opc_t o, input int dv);
        vec_t v;
        v = vi;
        v.prog[v.len] = mk(o, dv);
        v.len++;
        return v;
    endfunction

    // Reference: evaluate the queued program with a plain stack and count cycles
    // (CLEAR, then FETCH+CHECK per instruction, +EXEC+WAIT for issued ops).
    function automatic exp_t model(input int smax);
        exp_t        e;
        logic [15:0] st[$];
        logic [18:0] ins;
        logic [15:0] a, b;
        int          cyc;
        e = '{0, 0, 0, 0};
        cyc = 1;
        while (1) begin
            cyc++;
            if (mq.size() == 0) begin e.err = 3; break; end
            ins = mq.pop_front();
            cyc++;
            case (ins[18:16])
                3'd0: if (st.size() >= smax) e.err = 2;
                      else begin st.push_back(ins[15:0]); e.en++; cyc += 2; end
                3'd1: if (st.size() < 1) e.err = 1;
                      else begin a = st.pop_back(); a = 16'h0 - a; st.push_back(a); e.en++; cyc += 2; end
                3'd2, 3'd3: if (st.size() < 2) e.err = 1;
                      else begin
                          a = st.pop_back(); b = st.pop_back();
                          a = (ins[16]) ? b * a : b + a;
                          st.push_back(a); e.en++; cyc += 2;
                      end
                3'd4: begin
                    e.result = (st.size() > 0) ? int'(st[st.size()-1]) : 0;
                    e.dcyc = cyc + 1;
                    break;
                end
                default: ;
            endcase
            if (e.err != 0) begin mq.delete(); break; end
        end
        return e;
    endfunction

    task automatic load(input int d, input logic [18:0] ins, input bit exp_rdy, input string nm);
        @(negedge clk);
        in_instr = ins;
        in_valid_v[d] = 1'b1;
        chk(nm, in_ready_v[d], exp_rdy);
        @(negedge clk);
        in_valid_v[d] = 1'b0;
    endtask

    // Pulse start; cycle 1 is the one right after the edge that samples it.
    task automatic run_prog(input int d, input bit pulse, output int en, output int dn,
                            output int dcyc, output bit to);
        int cyc;
        en = 0; dn = 0; dcyc = 0; to = 1'b1; cyc = 0;
        @(negedge clk);
        start_v[d] = 1'b1;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            start_v[d] = pulse && (cyc == 5);
            if (calc_en_v[d]) en++;
            if (done_v[d]) begin dn++; dcyc = cyc; end
            if (!busy_v[d]) begin to = 1'b0; break; end
        end
        start_v[d] = 1'b0;
    endtask

    task automatic do_run(input string nm, input int d, input int ee, input int er,
                          input int een, input int edc, input bit pulse);
        int en, dn, dc;
        bit to;
        run_prog(d, pulse, en, dn, dc, to);
        chk({nm, "_timeout"}, to, 0);
        chk({nm, "_err"}, err_v[d], ee);
        chk({nm, "_result"}, result_v[d], er);
        chk({nm, "_calc_en"}, en, een);
        chk({nm, "_done_cnt"}, dn, (ee == 0) ? 1 : 0);
        if (ee == 0) chk({nm, "_done_cyc"}, dc, edc);
    endtask

    function automatic logic [18:0] rand_instr(input bit last);
        int r;
        r = $urandom_range(0, 99);
        if (last && r < 70) return mk(OP_END, 0);
        r = $urandom_range(0, 99);
        if (r < 45) return mk(OP_PUSH, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 20) : int'($urandom));
        if (r < 55) return mk(OP_NEG, $urandom);
        if (r < 70) return mk(OP_ADD, $urandom);
        if (r < 80) return mk(OP_MUL, $urandom);
        if (r < 90) return {3'($urandom_range(5, 7)), 16'($urandom)};
        return mk(OP_END, 0);
    endfunction

    initial begin
        vec_t v;
        vec_t tv[$];
        exp_t e;

        rst = 1'b1; in_instr = '0; in_valid_v = '0; start_v = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready_low", in_ready_v[0], 0);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy_v[d], 0);
            chk("rst_done", done_v[d], 0);
            chk("rst_err", err_v[d], 0);
            chk("rst_result", result_v[d], 0);
            chk("rst_calc_en", calc_en_v[d], 0);
            chk("rst_calc_clr", calc_clr_v[d], 0);
            chk("rst_calc_d", calc_d_v[d], 0);
            chk("rst_in_ready", in_ready_v[d], 1);
        end

        v = mkv("arith", 0, 35, 5, 24);
        v = ap(v, OP_PUSH, 3); v = ap(v, OP_PUSH, 4); v = ap(v, OP_ADD, 0);
        v = ap(v, OP_PUSH, 5); v = ap(v, OP_MUL, 0); v = ap(v, OP_END, 0);
        tv.push_back(v);
        v = mkv("neg", 0, 16'hFFFB, 2, 12);
        v = ap(v, OP_PUSH, 5); v = ap(v, OP_NEG, 0); v = ap(v, OP_END, 0);
        tv.push_back(v);
        v = mkv("mulwrap", 0, 24464, 3, 16);
        v = ap(v, OP_PUSH, 300); v = ap(v, OP_PUSH, 300); v = ap(v, OP_MUL, 0); v = ap(v, OP_END, 0);
        tv.push_back(v);
        v = mkv("add_under", 1, 0, 1, 0);
        v = ap(v, OP_PUSH, 7); v = ap(v, OP_ADD, 0); v = ap(v, OP_END, 0);
        tv.push_back(v);
        v = mkv("nops", 0, 3, 3, 20);
        v = ap(v, OP_PUSH, 1); v = ap(v, OP_NOP5, 9); v = ap(v, OP_PUSH, 2);
        v = ap(v, OP_NOP7, 0); v = ap(v, OP_ADD, 0); v = ap(v, OP_END, 0);
        tv.push_back(v);
        v = mkv("neg_under", 1, 0, 0, 0);
        v = ap(v, OP_NEG, 0); v = ap(v, OP_END, 0);
        tv.push_back(v);
        v = mkv("empty", 3, 0, 0, 0);
        tv.push_back(v);
        v = mkv("end_only", 0, 0, 0, 4);
        v = ap(v, OP_END, 0);
        tv.push_back(v);

        foreach (tv[i]) begin
            for (int j = 0; j < tv[i].len; j++) load(0, tv[i].prog[j], 1'b1, {tv[i].nm, "_rdy"});
            do_run(tv[i].nm, 0, tv[i].e_err, tv[i].e_res, tv[i].e_en, tv[i].e_dcyc, 1'b0);
            chk({tv[i].nm, "_in_ready_after"}, in_ready_v[0], 1);
        end

        // Instructions after END stay queued; start during busy is ignored.
        load(0, mk(OP_PUSH, 2), 1'b1, "left_rdy");
        load(0, mk(OP_END, 0),  1'b1, "left_rdy");
        load(0, mk(OP_PUSH, 9), 1'b1, "left_rdy");
        load(0, mk(OP_END, 0),  1'b1, "left_rdy");
        do_run("left1", 0, 0, 2, 1, 8, 1'b1);
        do_run("left2", 0, 0, 9, 1, 8, 1'b0);

        // Overflow and missing END on the small-stack instance.
        load(1, mk(OP_PUSH, 1), 1'b1, "ovf_rdy");
        load(1, mk(OP_PUSH, 2), 1'b1, "ovf_rdy");
        load(1, mk(OP_PUSH, 3), 1'b1, "ovf_rdy");
        load(1, mk(OP_END, 0),  1'b1, "ovf_rdy");
        do_run("overflow", 1, 2, 0, 2, 0, 1'b0);
        load(1, mk(OP_PUSH, 1), 1'b1, "noend_rdy");
        do_run("noend", 1, 3, 0, 1, 0, 1'b0);

        // Fill the FIFO, then reset during EXEC of the second instruction.
        for (int k = 0; k < 15; k++) load(0, mk(OP_PUSH, k + 1), 1'b1, "fill_rdy");
        load(0, mk(OP_END, 0), 1'b1, "fill_rdy");
        load(0, mk(OP_PUSH, 99), 1'b0, "full_in_ready");
        @(negedge clk);
        start_v[0] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        chk("pre_rst_calc_en", calc_en_v[0], 1);
        chk("pre_rst_calc_d", calc_d_v[0], 2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy_v[0], 0);
        chk("mid_rst_calc_en", calc_en_v[0], 0);
        chk("mid_rst_calc_push", calc_push_v[0], 0);
        chk("mid_rst_calc_d", calc_d_v[0], 0);
        chk("mid_rst_calc_op", calc_op_v[0], 0);
        chk("mid_rst_calc_clr", calc_clr_v[0], 0);
        chk("mid_rst_done", done_v[0], 0);
        chk("mid_rst_err", err_v[0], 0);
        chk("mid_rst_result", result_v[0], 0);
        chk("mid_rst_in_ready", in_ready_v[0], 0);
        @(negedge clk);
        chk("rst_hold_calc_en", calc_en_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        #1;
        chk("post_rst_in_ready", in_ready_v[0], 1);
        do_run("post_rst_empty", 0, 3, 0, 0, 0, 1'b0);

        // Randomised programs against the reference model, leftovers carried over.
        for (int it = 0; it < 40; it++) begin
            int          n;
            logic [18:0] ins;
            n = (mq.size() < 16) ? int'($urandom_range(1, 16 - mq.size())) : 0;
            for (int j = 0; j < n; j++) begin
                ins = rand_instr(j == n - 1);
                load(0, ins, 1'b1, "rnd_rdy");
                mq.push_back(ins);
            end
            e = model(1000);
            do_run("rnd", 0, e.err, e.result, e.en, e.dcyc, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
